// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive sequencing controller.
//   rx_state_e : states of the unload FSM (IDLE -> UNLOAD -> CAPTURE)
//   DEF_DIV_W  : default width of the baud divisor input
//   DEF_DEPTH  : default number of entries in the output byte FIFO
package uart_rx_pkg;

  localparam int DEF_DIV_W = 16;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UNLOAD  = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/rx_byte_fifo.sv
// Synchronous DEPTH x 8 circular-buffer FIFO for received bytes.
//   rxclk        : clock
//   reset        : asynchronous active-low reset
//   push_i       : write push_data_i (ignored when full and not popping)
//   push_data_i  : byte to store
//   pop_i        : remove head entry (ignored when empty)
//   head_data_o  : head entry, read combinationally; 0 when empty
//   count_o      : number of entries held, 0..DEPTH
module rx_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [7:0]       push_data_i,
  input  logic             pop_i,
  output logic [7:0]       head_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty;
  // A full FIFO can still accept a byte when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held (which would infer a latch).
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the count and pointers
  // define which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge rxclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Gate the head to zero when empty so the output is defined out of reset.
  assign head_data_o = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule : rx_byte_fifo

// File: rtl/uart_rx_ctrl.sv
// Sequencing controller for the UART receiver datapath.
// Generates the oversample enable, unloads completed bytes from the receiver
// and buffers them in a small FIFO with a valid/ready consumer interface.
//   rxclk       : clock (shared with the receiver)
//   reset       : asynchronous active-low reset
//   ctrl_en     : enable for rxen generation
//   div         : rxen period in rxclk cycles (0 or 1 => rxen every cycle)
//   rx_done     : one-cycle pulse, receiver has a new byte in rxrcvd
//   rx_data     : receiver rxrcvd bus
//   rxen        : receiver enable tick
//   rxuld       : receiver unload strobe, one cycle
//   m_data      : FIFO head byte
//   m_valid     : FIFO non-empty
//   m_ready     : consumer accepts m_data
//   fifo_count  : entries held, 0..DEPTH
//   overrun     : sticky, a byte was lost in the receiver
//   clr_overrun : clears overrun (a simultaneous new overrun wins)
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             ctrl_en,
  input  logic [DIV_W-1:0] div,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic             rxen,
  output logic             rxuld,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // ---------------------------------------------------------------- tick gen
  logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             rxen_q, rxen_d;

  always_comb begin
    tick_cnt_d = '0;
    rxen_d     = 1'b0;
    if (ctrl_en) begin
      if (div <= DIV_W'(1)) begin
        rxen_d = 1'b1;
      end else if (tick_cnt_q >= div - 1'b1) begin
        // '>=' lets a shrunken divisor wrap on the next cycle instead of
        // running the counter all the way round.
        rxen_d = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      rxen_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rxen_q     <= rxen_d;
    end
  end

  // -------------------------------------------------------- pending / overrun
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic rxuld_q;
  logic overrun_set;

  // A byte arriving in the unload cycle replaces the one being unloaded, so
  // it is not an overrun.
  assign overrun_set = rx_done & pending_q & ~rxuld_q;

  always_comb begin
    pending_d = rx_done | (pending_q & ~rxuld_q);
    overrun_d = overrun_q;
    if (overrun_set)      overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------- unload FSM
  rx_state_e        state_q;
  logic             fifo_push;
  logic [CNT_W-1:0] count;

  // Only one byte is ever in flight, so a free slot seen in IDLE is still
  // free at CAPTURE (pops can only add space).
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rxuld_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q && (count < FULL_CNT)) begin
            state_q <= ST_UNLOAD;
            rxuld_q <= 1'b1;
          end
        end
        ST_UNLOAD: begin
          state_q <= ST_CAPTURE;
          rxuld_q <= 1'b0;
        end
        ST_CAPTURE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          rxuld_q <= 1'b0;
        end
      endcase
    end
  end

  // rx_data is stable in the cycle after the unload strobe.
  assign fifo_push = (state_q == ST_CAPTURE);

  // --------------------------------------------------------------------- FIFO
  rx_byte_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .rxclk       (rxclk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (rx_data),
    .pop_i       (m_valid & m_ready),
    .head_data_o (m_data),
    .count_o     (count)
  );

  assign m_valid    = (count != '0);
  assign fifo_count = count;
  assign rxen       = rxen_q;
  assign rxuld      = rxuld_q;
  assign overrun    = overrun_q;

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl (DIV_W=16, DEPTH=4).
module tb_uart_rx_ctrl;

  logic        rxclk;
  logic        reset;
  logic        ctrl_en;
  logic [15:0] div;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        rxen;
  logic        rxuld;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        clr_overrun;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx_ctrl #(
    .DIV_W (16),
    .DEPTH (4),
    .CNT_W (3)
  ) dut (
    .rxclk       (rxclk),
    .reset       (reset),
    .ctrl_en     (ctrl_en),
    .div         (div),
    .rx_done     (rx_done),
    .rx_data     (rx_data),
    .rxen        (rxen),
    .rxuld       (rxuld),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .fifo_count  (fifo_count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial begin
    rxclk = 1'b0;
    forever #5 rxclk = ~rxclk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge rxclk);
    #1;
  endtask

  // One-cycle rx_done with the byte left on rx_data afterwards (as rxrcvd holds it).
  task automatic pulse_rx(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  // Wait (bounded) for m_valid, compare the head byte, then pop it.
  task automatic expect_pop(input string tag, input logic [7:0] exp);
    int w = 0;
    while (!m_valid && w < 10) begin
      step();
      w++;
    end
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_data"}, m_data, exp);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  initial begin
    int uld_seen;
    logic [7:0] drain_exp [5];

    reset       = 1'b0;
    ctrl_en     = 1'b1;
    div         = 16'd4;
    rx_done     = 1'b0;
    rx_data     = 8'h00;
    m_ready     = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) @(posedge rxclk);
    #1;

    // Reset state
    check("rst_rxen", rxen, 0);
    check("rst_rxuld", rxuld, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overrun", overrun, 0);

    // Tick generator, div=4: pulses after edges 4, 8, 12
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("rxen_div4_c%0d", k), rxen, (k % 4 == 0));
    end
    div = 16'd0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rxen_div0_c%0d", k), rxen, 1);
    end
    ctrl_en = 1'b0;
    step();
    check("rxen_disabled", rxen, 0);
    div = 16'd4;

    // Single byte: rxuld at +2, valid at +4
    pulse_rx(8'hA5);
    step();
    check("single_rxuld", rxuld, 1);
    step();
    check("single_rxuld_off", rxuld, 0);
    check("single_not_yet_valid", m_valid, 0);
    step();
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 8'hA5);
    check("single_count", fifo_count, 1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("single_count_pop", fifo_count, 0);
    check("single_valid_pop", m_valid, 0);

    // Fill: 5 bytes, 4 fit; the 5th stays pending with no unload
    uld_seen = 0;
    for (int i = 1; i <= 5; i++) begin
      pulse_rx(8'(i));
      for (int s = 0; s < 4; s++) begin
        step();
        if (i == 5 && rxuld) uld_seen++;
      end
    end
    check("fill_no_uld", uld_seen, 0);
    check("fill_count", fifo_count, 4);
    check("fill_overrun", overrun, 0);
    check("fill_head", m_data, 8'h01);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("fill_pop_count", fifo_count, 3);
    check("fill_pop_rxuld0", rxuld, 0);
    step();
    check("fill_late_rxuld", rxuld, 1);
    step();
    step();
    check("fill_refull", fifo_count, 4);

    // Overrun: full FIFO, byte pending, another rx_done
    pulse_rx(8'h06);
    check("ovr_first_pending", overrun, 0);
    step();
    pulse_rx(8'h07);
    check("ovr_set", overrun, 1);
    step();
    step();
    check("ovr_sticky", overrun, 1);
    rx_data     = 8'h08;
    rx_done     = 1'b1;
    clr_overrun = 1'b1;
    step();
    rx_done     = 1'b0;
    clr_overrun = 1'b0;
    check("ovr_set_wins", overrun, 1);
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    check("ovr_cleared", overrun, 0);
    check("ovr_count", fifo_count, 4);
    check("ovr_no_uld", rxuld, 0);

    // Drain: 0x02..0x05, then the pending byte 0x08 enters as space frees
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h08};
    for (int i = 0; i < 5; i++) expect_pop($sformatf("drain%0d", i), drain_exp[i]);
    check("drain_empty", fifo_count, 0);

    // rx_done during rxuld: no overrun, second unload 3 cycles later
    pulse_rx(8'h11);
    step();
    check("sim_uld1", rxuld, 1);
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    check("sim_no_overrun", overrun, 0);
    check("sim_uld_off", rxuld, 0);
    step();
    check("sim_count1", fifo_count, 1);
    check("sim_gap_uld", rxuld, 0);
    rx_data = 8'h22;
    step();
    check("sim_uld2", rxuld, 1);
    step();
    step();
    check("sim_count2", fifo_count, 2);

    // Push and pop in the same cycle at count=2
    pulse_rx(8'h33);
    step();
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("pushpop_count", fifo_count, 2);
    check("pushpop_head", m_data, 8'h22);
    expect_pop("pp_a", 8'h22);
    expect_pop("pp_b", 8'h33);
    check("pp_empty", fifo_count, 0);

    // Asynchronous reset during UNLOAD
    pulse_rx(8'h44);
    repeat (3) step();
    check("rstu_count1", fifo_count, 1);
    ctrl_en = 1'b1;
    div     = 16'd0;
    pulse_rx(8'h55);
    step();
    check("rstu_in_unload", rxuld, 1);
    check("rstu_rxen_on", rxen, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstu_rxen", rxen, 0);
    check("rstu_rxuld", rxuld, 0);
    check("rstu_m_valid", m_valid, 0);
    check("rstu_m_data", m_data, 0);
    check("rstu_count", fifo_count, 0);
    check("rstu_overrun", overrun, 0);
    ctrl_en = 1'b0;
    step();
    reset = 1'b1;
    uld_seen = 0;
    for (int s = 0; s < 5; s++) begin
      step();
      if (rxuld) uld_seen++;
    end
    check("post_rst_no_uld", uld_seen, 0);
    check("post_rst_count", fifo_count, 0);
    pulse_rx(8'h66);
    step();
    check("post_rst_uld", rxuld, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_uart_rx_ctrl
